// File: rtl/dram_axi_pkg.sv
// Shared definitions for the L2-to-DRAM AXI-style interface.
// Contents: bus width defaults shared with the L2 cache, response encodings,
// the five channel packet types and a byte-lane merge helper.
package dram_axi_pkg;

   localparam int ADDR_W = 32;
   localparam int DATA_W = 64;
   localparam int ID_W   = 4;
   localparam int STRB_W = DATA_W / 8;

   localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
   localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

   typedef struct packed {
      logic              valid;
      logic [ID_W-1:0]   id;
      logic [ADDR_W-1:0] addr;
   } address_read_packet_t;

   typedef struct packed {
      logic              valid;
      logic [ID_W-1:0]   id;
      logic [DATA_W-1:0] data;
      logic [1:0]        resp;
      logic              last;
   } read_data_packet_t;

   typedef struct packed {
      logic              valid;
      logic [ID_W-1:0]   id;
      logic [ADDR_W-1:0] addr;
   } address_write_packet_t;

   typedef struct packed {
      logic              valid;
      logic [DATA_W-1:0] data;
      logic [STRB_W-1:0] strb;
      logic              last;
   } write_data_packet_t;

   typedef struct packed {
      logic            valid;
      logic [ID_W-1:0] id;
      logic [1:0]      resp;
   } write_response_packet_t;

   // Byte-lane merge: lanes with strb set take wr_data, the rest keep old_data.
   function automatic logic [DATA_W-1:0] merge_bytes(input logic [DATA_W-1:0] old_data,
                                                     input logic [DATA_W-1:0] wr_data,
                                                     input logic [STRB_W-1:0] strb);
      logic [DATA_W-1:0] merged;
      merged = old_data;
      for (int i = 0; i < STRB_W; i++) begin
         if (strb[i]) begin
            merged[8*i +: 8] = wr_data[8*i +: 8];
         end else begin
            merged[8*i +: 8] = old_data[8*i +: 8];
         end
      end
      return merged;
   endfunction

endpackage

// File: rtl/dram_rd_queue.sv
// In-order read request FIFO with a per-entry latency countdown.
// Ports:
//   clock, reset            - clock, synchronous active-high reset
//   push, push_id, push_addr - enqueue a request (ignored when full)
//   pop                     - dequeue the head (ignored when empty)
//   head_id, head_addr      - head entry fields
//   head_ready              - head present and its countdown has reached 0
//   full, empty             - occupancy flags from the registered count
module dram_rd_queue
   import dram_axi_pkg::*;
#(
   parameter int DEPTH   = 4,
   parameter int LATENCY = 8
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              push,
   input  logic [ID_W-1:0]   push_id,
   input  logic [ADDR_W-1:0] push_addr,
   input  logic              pop,
   output logic [ID_W-1:0]   head_id,
   output logic [ADDR_W-1:0] head_addr,
   output logic              head_ready,
   output logic              full,
   output logic              empty
);

   localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNTR_W = PTR_W + 1;
   localparam int CNT_W  = $clog2(LATENCY + 1);
   // A fresh entry starts at LATENCY-1 so the issue edge lands LATENCY edges after the push edge.
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

   logic [ID_W-1:0]   id_q   [DEPTH];
   logic [ID_W-1:0]   id_d   [DEPTH];
   logic [ADDR_W-1:0] addr_q [DEPTH];
   logic [ADDR_W-1:0] addr_d [DEPTH];
   logic [CNT_W-1:0]  cnt_q  [DEPTH];
   logic [CNT_W-1:0]  cnt_d  [DEPTH];
   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
   logic [CNTR_W-1:0] count_q, count_d;
   logic              push_ok;
   logic              pop_ok;

   assign full       = (count_q == CNTR_W'(DEPTH));
   assign empty      = (count_q == {CNTR_W{1'b0}});
   assign head_id    = id_q[rd_ptr_q];
   assign head_addr  = addr_q[rd_ptr_q];
   assign head_ready = !empty && (cnt_q[rd_ptr_q] == {CNT_W{1'b0}});
   assign push_ok    = push && !full;
   assign pop_ok     = pop && !empty;

   // Next-state for storage, countdowns, pointers and occupancy.
   always_comb begin
      id_d     = id_q;
      addr_d   = addr_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      // Every slot counts down; stale slots are harmless since a push reloads them.
      for (int i = 0; i < DEPTH; i++) begin
         if (cnt_q[i] != {CNT_W{1'b0}}) begin
            cnt_d[i] = cnt_q[i] - CNT_W'(1);
         end else begin
            cnt_d[i] = cnt_q[i];
         end
      end
      if (push_ok) begin
         id_d[wr_ptr_q]   = push_id;
         addr_d[wr_ptr_q] = push_addr;
         cnt_d[wr_ptr_q]  = CNT_LOAD;
         wr_ptr_d         = wr_ptr_q + PTR_W'(1);
      end else begin
         wr_ptr_d = wr_ptr_q;
      end
      if (pop_ok) begin
         rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end else begin
         rd_ptr_d = rd_ptr_q;
      end
      case ({push_ok, pop_ok})
         2'b10:   count_d = count_q + CNTR_W'(1);
         2'b01:   count_d = count_q - CNTR_W'(1);
         default: count_d = count_q;
      endcase
   end

   // Queue state register.
   always_ff @(posedge clock) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            id_q[i]   <= {ID_W{1'b0}};
            addr_q[i] <= {ADDR_W{1'b0}};
            cnt_q[i]  <= {CNT_W{1'b0}};
         end
         wr_ptr_q <= {PTR_W{1'b0}};
         rd_ptr_q <= {PTR_W{1'b0}};
         count_q  <= {CNTR_W{1'b0}};
      end else begin
         id_q     <= id_d;
         addr_q   <= addr_d;
         cnt_q    <= cnt_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

endmodule

// File: rtl/dram_axi_slave.sv
// DRAM responder for the L2 cache's AXI-style memory channels.
// One DATA_W word per cache line; every transfer is a single beat.
// Ports:
//   clock, reset          - clock, synchronous active-high reset
//   ar_packet / ar_ready  - read address in; ready while the read queue has room
//   r_packet / r_ready    - registered read data out
//   aw_packet / aw_ready  - write address in; ready while the AW holding register is empty
//   w_packet / w_ready    - write data in; ready while the W holding register is empty
//   b_packet / b_ready    - registered write response out
module dram_axi_slave
   import dram_axi_pkg::*;
#(
   parameter int MEM_WORDS   = 1024,
   parameter int RD_LATENCY  = 8,
   parameter int QUEUE_DEPTH = 4
) (
   input  logic                   clock,
   input  logic                   reset,
   input  address_read_packet_t   ar_packet,
   output logic                   ar_ready,
   output read_data_packet_t      r_packet,
   input  logic                   r_ready,
   input  address_write_packet_t  aw_packet,
   output logic                   aw_ready,
   input  write_data_packet_t     w_packet,
   output logic                   w_ready,
   output write_response_packet_t b_packet,
   input  logic                   b_ready
);

   localparam int OFF_W = $clog2(STRB_W);
   localparam int IDX_W = $clog2(MEM_WORDS);

   // Word index is the byte address with the in-word offset dropped.
   function automatic logic addr_in_range(input logic [ADDR_W-1:0] addr);
      logic [ADDR_W-1:0] word;
      word = addr >> OFF_W;
      return (word < ADDR_W'(MEM_WORDS));
   endfunction

   function automatic logic [IDX_W-1:0] mem_index(input logic [ADDR_W-1:0] addr);
      return addr[OFF_W +: IDX_W];
   endfunction

   logic [DATA_W-1:0]      mem_q [MEM_WORDS];
   read_data_packet_t      r_packet_q, r_packet_d;
   write_response_packet_t b_packet_q, b_packet_d;
   logic                   aw_held_q, aw_held_d;
   logic [ID_W-1:0]        aw_id_q, aw_id_d;
   logic [ADDR_W-1:0]      aw_addr_q, aw_addr_d;
   logic                   w_held_q, w_held_d;
   logic [DATA_W-1:0]      w_data_q, w_data_d;
   logic [STRB_W-1:0]      w_strb_q, w_strb_d;

   logic                   q_full, q_empty, q_head_ready;
   logic [ID_W-1:0]        q_head_id;
   logic [ADDR_W-1:0]      q_head_addr;
   logic                   ar_fire, aw_fire, w_fire;
   logic                   r_issue, wr_commit, mem_we;
   logic                   wr_in_range, rd_in_range;
   logic [IDX_W-1:0]       wr_idx, rd_idx;
   logic [DATA_W-1:0]      wr_merged, rd_data;
   logic                   w_last_unused;

   // Single-beat transfers: the W last flag carries no information.
   assign w_last_unused = w_packet.last;

   assign r_packet = r_packet_q;
   assign b_packet = b_packet_q;

   dram_rd_queue #(
      .DEPTH   (QUEUE_DEPTH),
      .LATENCY (RD_LATENCY)
   ) u_rd_queue (
      .clock      (clock),
      .reset      (reset),
      .push       (ar_fire),
      .push_id    (ar_packet.id),
      .push_addr  (ar_packet.addr),
      .pop        (r_issue),
      .head_id    (q_head_id),
      .head_addr  (q_head_addr),
      .head_ready (q_head_ready),
      .full       (q_full),
      .empty      (q_empty)
   );

   // Handshake readiness, commit/issue decisions and memory access with write forwarding.
   always_comb begin
      ar_ready    = !reset && !q_full;
      aw_ready    = !reset && !aw_held_q;
      w_ready     = !reset && !w_held_q;
      ar_fire     = ar_packet.valid && ar_ready;
      aw_fire     = aw_packet.valid && aw_ready;
      w_fire      = w_packet.valid && w_ready;
      r_issue     = q_head_ready && (!r_packet_q.valid || r_ready);
      wr_commit   = aw_held_q && w_held_q && (!b_packet_q.valid || b_ready);
      wr_in_range = addr_in_range(aw_addr_q);
      wr_idx      = mem_index(aw_addr_q);
      wr_merged   = merge_bytes(mem_q[wr_idx], w_data_q, w_strb_q);
      mem_we      = wr_commit && wr_in_range;
      rd_in_range = addr_in_range(q_head_addr);
      rd_idx      = mem_index(q_head_addr);
      // A read issuing alongside a commit to the same word sees the merged value.
      if (mem_we && (wr_idx == rd_idx)) begin
         rd_data = wr_merged;
      end else begin
         rd_data = mem_q[rd_idx];
      end
   end

   // R output register next-state: load on issue, clear on acceptance, else hold.
   always_comb begin
      r_packet_d = r_packet_q;
      if (r_issue) begin
         r_packet_d.valid = 1'b1;
         r_packet_d.id    = q_head_id;
         r_packet_d.last  = 1'b1;
         if (rd_in_range) begin
            r_packet_d.data = rd_data;
            r_packet_d.resp = AXI_RESP_OKAY;
         end else begin
            r_packet_d.data = {DATA_W{1'b0}};
            r_packet_d.resp = AXI_RESP_SLVERR;
         end
      end else if (r_packet_q.valid && r_ready) begin
         r_packet_d = {$bits(read_data_packet_t){1'b0}};
      end else begin
         r_packet_d = r_packet_q;
      end
   end

   // Write holding registers and B output register next-state.
   always_comb begin
      aw_held_d  = aw_held_q;
      aw_id_d    = aw_id_q;
      aw_addr_d  = aw_addr_q;
      w_held_d   = w_held_q;
      w_data_d   = w_data_q;
      w_strb_d   = w_strb_q;
      b_packet_d = b_packet_q;
      // Captures need an empty register and a commit needs both full, so they never collide.
      if (wr_commit) begin
         aw_held_d = 1'b0;
         w_held_d  = 1'b0;
      end else begin
         if (aw_fire) begin
            aw_held_d = 1'b1;
            aw_id_d   = aw_packet.id;
            aw_addr_d = aw_packet.addr;
         end else begin
            aw_held_d = aw_held_q;
         end
         if (w_fire) begin
            w_held_d = 1'b1;
            w_data_d = w_packet.data;
            w_strb_d = w_packet.strb;
         end else begin
            w_held_d = w_held_q;
         end
      end
      if (wr_commit) begin
         b_packet_d.valid = 1'b1;
         b_packet_d.id    = aw_id_q;
         b_packet_d.resp  = wr_in_range ? AXI_RESP_OKAY : AXI_RESP_SLVERR;
      end else if (b_packet_q.valid && b_ready) begin
         b_packet_d = {$bits(write_response_packet_t){1'b0}};
      end else begin
         b_packet_d = b_packet_q;
      end
   end

   // Output and holding register state.
   always_ff @(posedge clock) begin
      if (reset) begin
         r_packet_q <= {$bits(read_data_packet_t){1'b0}};
         b_packet_q <= {$bits(write_response_packet_t){1'b0}};
         aw_held_q  <= 1'b0;
         aw_id_q    <= {ID_W{1'b0}};
         aw_addr_q  <= {ADDR_W{1'b0}};
         w_held_q   <= 1'b0;
         w_data_q   <= {DATA_W{1'b0}};
         w_strb_q   <= {STRB_W{1'b0}};
      end else begin
         r_packet_q <= r_packet_d;
         b_packet_q <= b_packet_d;
         aw_held_q  <= aw_held_d;
         aw_id_q    <= aw_id_d;
         aw_addr_q  <= aw_addr_d;
         w_held_q   <= w_held_d;
         w_data_q   <= w_data_d;
         w_strb_q   <= w_strb_d;
      end
   end

   // Backing store: cleared by reset, one merged word written per commit.
   always_ff @(posedge clock) begin
      if (reset) begin
         for (int i = 0; i < MEM_WORDS; i++) begin
            mem_q[i] <= {DATA_W{1'b0}};
         end
      end else if (mem_we) begin
         mem_q[wr_idx] <= wr_merged;
      end
   end

endmodule
